cr_xp10_decomp_be_frm_arb: RTL and testbench

- Frame-granular arbiter that shares one back-end frame checker (size/CRC/Adler) between two decompression back-end lanes.
- Grants a lane for a whole frame. A frame is data beats (data_type 2'b01) terminated by one trailer beat (data_type != 2'b01).
- Forwards the granted lane's beats to the checker.
- Tracks frame ownership and routes the checker's size_error/crc_error result back to the lane that owned the frame.
- Sits between the two lz back-end datapaths and the single frame-check instance.

---
 rtl/cr_xp10_decomp_be_frm_arb.sv | 174 +++++++++++++++++
 tb/tb_cr_xp10_decomp_be_frm_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_xp10_decomp_be_frm_arb.sv
// Frame-granular arbiter sharing one back-end frame checker between two lanes.
// Optional per-lane frame/error counters: define CR_XP10_DECOMP_BE_FRM_ARB_STATS_EN.
module cr_xp10_decomp_be_frm_arb #(
    parameter int unsigned RES_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_data,
    input  logic [7:0]  req0_bytes_valid,
    input  logic [1:0]  req0_data_type,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_data,
    input  logic [7:0]  req1_bytes_valid,
    input  logic [1:0]  req1_data_type,

    output logic        chk_valid,
    output logic [63:0] chk_data,
    output logic [7:0]  chk_bytes_valid,
    output logic [1:0]  chk_data_type,
    input  logic        chk_size_error,
    input  logic        chk_crc_error,

    output logic        res0_valid,
    output logic        res0_size_error,
    output logic        res0_crc_error,
    output logic        res1_valid,
    output logic        res1_size_error,
    output logic        res1_crc_error,

    output logic        busy
`ifdef CR_XP10_DECOMP_BE_FRM_ARB_STATS_EN
    ,
    output logic [15:0] stat0_frames,
    output logic [15:0] stat0_errors,
    output logic [15:0] stat1_frames,
    output logic [15:0] stat1_errors
`endif
);

    if (RES_LAT < 1 || RES_LAT > 8) begin : g_bad_res_lat
        $error("RES_LAT must be in 1..8");
    end

    localparam logic [1:0] DataBeat = 2'b01;

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e      state;
    logic        rr_ptr;

    logic        gnt_lane;
    logic        acc;
    logic        trl_acc;
    logic [63:0] sel_data;
    logic [7:0]  sel_bytes;
    logic [1:0]  sel_type;

    // Tag pipe: bit k holds the frame-result tag k cycles after its trailer was accepted.
    logic [RES_LAT:0] tag_vld;
    logic [RES_LAT:0] tag_lane;
    logic             fin_vld;
    logic             fin_lane;

    always_comb begin
        req0_ready = (state == StGnt0);
        req1_ready = (state == StGnt1);
        gnt_lane   = (state == StGnt1);
        sel_data   = gnt_lane ? req1_data        : req0_data;
        sel_bytes  = gnt_lane ? req1_bytes_valid : req0_bytes_valid;
        sel_type   = gnt_lane ? req1_data_type   : req0_data_type;
        acc        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        trl_acc    = acc && (sel_type != DataBeat);
    end

    // Grant FSM; a grant lasts until the owning lane's trailer is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= StIdle;
            rr_ptr <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req0_valid && (!req1_valid || !rr_ptr)) begin
                        state <= StGnt0;
                    end else if (req1_valid) begin
                        state <= StGnt1;
                    end
                end
                StGnt0: begin
                    if (trl_acc) begin
                        state  <= StIdle;
                        rr_ptr <= 1'b1;
                    end
                end
                StGnt1: begin
                    if (trl_acc) begin
                        state  <= StIdle;
                        rr_ptr <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Checker beat register; data fields hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_valid       <= 1'b0;
            chk_data        <= 64'd0;
            chk_bytes_valid <= 8'd0;
            chk_data_type   <= 2'd0;
        end else begin
            chk_valid <= acc;
            if (acc) begin
                chk_data        <= sel_data;
                chk_bytes_valid <= sel_bytes;
                chk_data_type   <= sel_type;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld  <= '0;
            tag_lane <= '0;
        end else begin
            tag_vld  <= {tag_vld[RES_LAT-1:0], trl_acc};
            tag_lane <= {tag_lane[RES_LAT-1:0], trl_acc & gnt_lane};
        end
    end

    always_comb begin
        fin_vld         = tag_vld[RES_LAT];
        fin_lane        = tag_lane[RES_LAT];
        res0_valid      = fin_vld && !fin_lane;
        res1_valid      = fin_vld && fin_lane;
        res0_size_error = res0_valid && chk_size_error;
        res0_crc_error  = res0_valid && chk_crc_error;
        res1_size_error = res1_valid && chk_size_error;
        res1_crc_error  = res1_valid && chk_crc_error;
        busy            = (state != StIdle) || (|tag_vld);
    end

`ifdef CR_XP10_DECOMP_BE_FRM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat0_frames <= 16'd0;
            stat0_errors <= 16'd0;
            stat1_frames <= 16'd0;
            stat1_errors <= 16'd0;
        end else begin
            if (res0_valid && stat0_frames != 16'hFFFF) begin
                stat0_frames <= stat0_frames + 16'd1;
            end
            if ((res0_size_error || res0_crc_error) && stat0_errors != 16'hFFFF) begin
                stat0_errors <= stat0_errors + 16'd1;
            end
            if (res1_valid && stat1_frames != 16'hFFFF) begin
                stat1_frames <= stat1_frames + 16'd1;
            end
            if ((res1_size_error || res1_crc_error) && stat1_errors != 16'hFFFF) begin
                stat1_errors <= stat1_errors + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cr_xp10_decomp_be_frm_arb.sv
// Directed bench for cr_xp10_decomp_be_frm_arb with RES_LAT = 2.
module tb_cr_xp10_decomp_be_frm_arb;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_data, req1_data, chk_data;
    logic [7:0]  req0_bytes_valid, req1_bytes_valid, chk_bytes_valid;
    logic [1:0]  req0_data_type, req1_data_type, chk_data_type;
    logic        chk_valid, chk_size_error, chk_crc_error;
    logic        res0_valid, res0_size_error, res0_crc_error;
    logic        res1_valid, res1_size_error, res1_crc_error;
    logic        busy;
`ifdef CR_XP10_DECOMP_BE_FRM_ARB_STATS_EN
    logic [15:0] stat0_frames, stat0_errors, stat1_frames, stat1_errors;
`endif

    int n_chk;
    int n_fail;

    cr_xp10_decomp_be_frm_arb #(.RES_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_bytes_valid(req0_bytes_valid), .req0_data_type(req0_data_type),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_bytes_valid(req1_bytes_valid), .req1_data_type(req1_data_type),
        .chk_valid(chk_valid), .chk_data(chk_data), .chk_bytes_valid(chk_bytes_valid),
        .chk_data_type(chk_data_type), .chk_size_error(chk_size_error),
        .chk_crc_error(chk_crc_error),
        .res0_valid(res0_valid), .res0_size_error(res0_size_error),
        .res0_crc_error(res0_crc_error),
        .res1_valid(res1_valid), .res1_size_error(res1_size_error),
        .res1_crc_error(res1_crc_error),
        .busy(busy)
`ifdef CR_XP10_DECOMP_BE_FRM_ARB_STATS_EN
        ,
        .stat0_frames(stat0_frames), .stat0_errors(stat0_errors),
        .stat1_frames(stat1_frames), .stat1_errors(stat1_errors)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive0(input logic v, input logic [63:0] d, input logic [7:0] b,
                          input logic [1:0] t);
        req0_valid = v; req0_data = d; req0_bytes_valid = b; req0_data_type = t;
    endtask

    task automatic drive1(input logic v, input logic [63:0] d, input logic [7:0] b,
                          input logic [1:0] t);
        req1_valid = v; req1_data = d; req1_bytes_valid = b; req1_data_type = t;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".req0_ready"}, req0_ready, 0);
        check({tag, ".req1_ready"}, req1_ready, 0);
        check({tag, ".chk_valid"}, chk_valid, 0);
        check({tag, ".chk_data"}, chk_data, 0);
        check({tag, ".chk_bytes_valid"}, chk_bytes_valid, 0);
        check({tag, ".chk_data_type"}, chk_data_type, 0);
        check({tag, ".res0_valid"}, res0_valid, 0);
        check({tag, ".res0_size_error"}, res0_size_error, 0);
        check({tag, ".res1_valid"}, res1_valid, 0);
        check({tag, ".busy"}, busy, 0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        chk_size_error = 1'b0;
        chk_crc_error = 1'b0;
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);

        // Lane 0: three data beats plus trailer, size error reported.
        tick(); tick(); #1;
        check_all_zero("rst");
        rst_n = 1'b1;
        drive0(1, 64'hA0, 8'hFF, 2'b01);
        tick(); #1;
        check("t1.gnt_ready0", req0_ready, 1);
        check("t1.gnt_ready1", req1_ready, 0);
        check("t1.gnt_chk_valid", chk_valid, 0);
        check("t1.gnt_busy", busy, 1);
        tick(); drive0(1, 64'hA1, 8'hFF, 2'b01); #1;
        check("t1.b0_valid", chk_valid, 1);
        check("t1.b0_data", chk_data, 64'hA0);
        tick(); drive0(1, 64'hA2, 8'hFF, 2'b01); #1;
        check("t1.b1_data", chk_data, 64'hA1);
        tick(); drive0(1, 64'hAF, 8'h07, 2'b10); #1;
        check("t1.b2_data", chk_data, 64'hA2);
        tick(); drive0(0, 0, 0, 0); #1;
        check("t1.trl_valid", chk_valid, 1);
        check("t1.trl_data", chk_data, 64'hAF);
        check("t1.trl_bytes", chk_bytes_valid, 8'h07);
        check("t1.trl_type", chk_data_type, 2'b10);
        check("t1.trl_ready0", req0_ready, 0);
        tick(); chk_size_error = 1'b1; #1;
        check("t1.idle_chk_valid", chk_valid, 0);
        check("t1.held_data", chk_data, 64'hAF);
        check("t1.early_res0", res0_valid, 0);
        tick(); #1;
        check("t1.res0_valid", res0_valid, 1);
        check("t1.res0_size", res0_size_error, 1);
        check("t1.res0_crc", res0_crc_error, 0);
        check("t1.res1_valid", res1_valid, 0);
        tick(); chk_size_error = 1'b0; #1;
        check("t1.res0_done", res0_valid, 0);
        check("t1.busy_done", busy, 0);

        // Both lanes, 2-beat frames: grants 0,1,0 with a bubble between frames.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive0(1, 64'h10, 8'hFF, 2'b01);
        drive1(1, 64'h20, 8'hFF, 2'b01);
        tick(); #1;
        check("t2.g0_ready0", req0_ready, 1);
        check("t2.g0_ready1", req1_ready, 0);
        tick(); drive0(1, 64'h11, 8'h0F, 2'b11); #1;
        check("t2.a0_data", chk_data, 64'h10);
        tick(); drive0(1, 64'h12, 8'hFF, 2'b01); #1;
        check("t2.a1_data", chk_data, 64'h11);
        check("t2.a1_type", chk_data_type, 2'b11);
        check("t2.bubble_ready0", req0_ready, 0);
        check("t2.bubble_ready1", req1_ready, 0);
        tick(); #1;
        check("t2.g1_ready1", req1_ready, 1);
        check("t2.g1_ready0", req0_ready, 0);
        check("t2.g1_chk_valid", chk_valid, 0);
        tick(); drive1(1, 64'h21, 8'h03, 2'b00); chk_crc_error = 1'b1; #1;
        check("t2.b0_data", chk_data, 64'h20);
        check("t2.r0_valid", res0_valid, 1);
        check("t2.r0_crc", res0_crc_error, 1);
        check("t2.r0_size", res0_size_error, 0);
        check("t2.r0_res1", res1_valid, 0);
        tick(); drive1(1, 64'h22, 8'hFF, 2'b01); chk_crc_error = 1'b0; #1;
        check("t2.b1_data", chk_data, 64'h21);
        check("t2.r0_done", res0_valid, 0);
        check("t2.bubble2_ready1", req1_ready, 0);
        tick(); #1;
        check("t2.g0b_ready0", req0_ready, 1);
        tick(); drive0(1, 64'h13, 8'hFF, 2'b10); drive1(0, 0, 0, 0); chk_size_error = 1'b1; #1;
        check("t2.a2_data", chk_data, 64'h12);
        check("t2.r1_valid", res1_valid, 1);
        check("t2.r1_size", res1_size_error, 1);
        check("t2.r1_res0", res0_valid, 0);
        tick(); drive0(0, 0, 0, 0); chk_size_error = 1'b0; #1;
        check("t2.a3_data", chk_data, 64'h13);
        check("t2.r1_done", res1_valid, 0);
        tick(); tick(); #1;
        check("t2.r0b_valid", res0_valid, 1);
        check("t2.r0b_size", res0_size_error, 0);
        tick(); #1;
        check("t2.busy_done", busy, 0);

        // Lane 1 single-trailer frame (rr_ptr now favours lane 1).
        drive1(1, 64'h30, 8'h01, 2'b00);
        tick(); #1;
        check("t3.ready1", req1_ready, 1);
        tick(); drive1(0, 0, 0, 0); #1;
        check("t3.chk_data", chk_data, 64'h30);
        check("t3.chk_type", chk_data_type, 2'b00);
        check("t3.released", req1_ready, 0);
        tick(); #1;
        check("t3.res1_early", res1_valid, 0);
        tick(); #1;
        check("t3.res1_pulse", res1_valid, 1);
        tick(); #1;
        check("t3.res1_once", res1_valid, 0);
        check("t3.busy", busy, 0);

        // Lane 0 stalls mid-frame while lane 1 waits.
        drive0(1, 64'h40, 8'hFF, 2'b01);
        drive1(1, 64'h50, 8'hFF, 2'b01);
        tick(); #1;
        check("t4.ready0", req0_ready, 1);
        tick(); drive0(0, 64'h40, 8'hFF, 2'b01); #1;
        check("t4.e0_data", chk_data, 64'h40);
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            check("t4.stall_ready1", req1_ready, 0);
            check("t4.stall_ready0", req0_ready, 1);
        end
        drive0(1, 64'h41, 8'hFF, 2'b10);
        tick(); drive0(0, 0, 0, 0); #1;
        check("t4.trl_data", chk_data, 64'h41);
        check("t4.trl_ready1", req1_ready, 0);
        tick(); #1;
        check("t4.g1_ready1", req1_ready, 1);

        // Reset with the lane 0 result still in flight.
        rst_n = 1'b0;
        chk_size_error = 1'b1;
        tick(); #1;
        check_all_zero("t5");
        rst_n = 1'b1;
        drive1(0, 0, 0, 0);
        chk_size_error = 1'b0;
        tick(); #1;
        check("t5.no_res0", res0_valid, 0);
        check("t5.busy", busy, 0);

`ifdef CR_XP10_DECOMP_BE_FRM_ARB_STATS_EN
        for (int k = 0; k < 3; k++) begin
            drive0(1, 64'h60 + 64'(k), 8'hFF, 2'b00);
            tick(); tick();
            drive0(0, 0, 0, 0);
            tick(); tick();
            chk_crc_error = (k == 1);
            tick();
            chk_crc_error = 1'b0;
        end
        #1;
        check("st.frames0", stat0_frames, 16'd3);
        check("st.errors0", stat0_errors, 16'd1);
        check("st.frames1", stat1_frames, 16'd0);
        check("st.errors1", stat1_errors, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
